// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared definitions for the toggle request/acknowledge crossing.
// Both the transmitter and the companion receiver import this package.
package cdc_hs_pkg;

    // State encoding for the handshake FSMs.
    localparam logic [1:0] CDC_HS_INIT = 2'd0;
    localparam logic [1:0] CDC_HS_IDLE = 2'd1;
    localparam logic [1:0] CDC_HS_WAIT = 2'd2;

    // Default depth of the ack/req synchronizers.
    localparam int CDC_HS_SYNC_STAGES = 2;

endpackage

// File: rtl/synchronizer.sv
// synchronizer: multi-flop single-bit synchronizer with selectable reset style.
// Brings an asynchronous level into the clk domain after STAGES edges.
module synchronizer #(
    parameter int   STAGES      = 2,
    parameter bit   ASYNC_RESET = 1'b0,
    parameter logic INIT        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    generate
        if (ASYNC_RESET) begin : g_async
            // Shift the asynchronous input through the chain, reset asynchronously.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_chain <= {STAGES{INIT}};
                else     r_chain <= {r_chain[STAGES-2:0], i_d};
            end
        end else begin : g_sync
            // Shift the asynchronous input through the chain, reset synchronously.
            always_ff @(posedge clk) begin
                if (rst) r_chain <= {STAGES{INIT}};
                else     r_chain <= {r_chain[STAGES-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-side transmitter of a 2-phase toggle req/ack crossing.
// Accepts one word, holds it on out_data, toggles out_req and waits for the
// synchronized ack toggle before accepting again. After reset an INIT phase
// aligns out_req to the far-side ack level so a non-reset far side sees no
// spurious request.
// Optional: define CDC_HS_TX_TIMEOUT_EN to add the sticky ack_tmo output,
// set after 2**TMO_BITS-1 cycles spent waiting for an ack.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = CDC_HS_SYNC_STAGES,
    parameter int TMO_BITS    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_req,
    input  logic             a_ack,
    output logic             busy,
`ifdef CDC_HS_TX_TIMEOUT_EN
    output logic             ack_tmo,
`endif
    output logic             proto_err
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_init_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_req;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_proto_err;
    logic             w_ack_s;
    logic             w_accept;

    synchronizer #(
        .STAGES      (SYNC_STAGES),
        .ASYNC_RESET (1'b0),
        .INIT        (1'b0)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .i_d (a_ack),
        .o_q (w_ack_s)
    );

    assign w_accept = (r_state == CDC_HS_IDLE) && in_valid;

    // Handshake FSM: phase alignment after reset, accept in IDLE, wait for ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CDC_HS_INIT;
            r_init_cnt  <= '0;
            r_out_data  <= '0;
            r_out_req   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                CDC_HS_INIT: begin
                    // Sync chain has settled on the far-side level by the last count.
                    if (r_init_cnt == INIT_LAST) begin
                        r_out_req  <= w_ack_s;
                        r_state    <= CDC_HS_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                CDC_HS_IDLE: begin
                    if (w_ack_s != r_out_req) r_proto_err <= 1'b1;
                    if (in_valid) begin
                        r_out_data <= in_data;
                        r_out_req  <= ~r_out_req;
                        r_state    <= CDC_HS_WAIT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                CDC_HS_WAIT: begin
                    if (w_ack_s == r_out_req) begin
                        r_state    <= CDC_HS_IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= CDC_HS_INIT;
                    r_init_cnt <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam logic [TMO_BITS-1:0] TMO_LAST = {TMO_BITS{1'b1}} - 1'b1;

    logic [TMO_BITS-1:0] r_tmo_cnt;
    logic                r_ack_tmo;

    // Count WAIT cycles, saturate at all-ones and flag a sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_ack_tmo <= 1'b0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == CDC_HS_WAIT && r_tmo_cnt != {TMO_BITS{1'b1}}) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (r_tmo_cnt == TMO_LAST) r_ack_tmo <= 1'b1;
        end
    end

    assign ack_tmo = r_ack_tmo;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_data  = r_out_data;
    assign out_req   = r_out_req;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed bench for the toggle handshake transmitter.
module tb_cdc_hs_tx;

    localparam int S = 2;
    localparam int W = 32;
    localparam int TURN = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;
    logic         out_req;
    logic         a_ack;
    logic         busy;
    logic         proto_err;
`ifdef CDC_HS_TX_TIMEOUT_EN
    logic         ack_tmo;
`endif

    logic a_ack_man;
    logic far_ack = 1'b0;
    logic far_seen = 1'b0;
    logic far_en;
    logic last_req = 1'b0;
    int   n_tog = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cnt;
    logic held_ok;

    assign a_ack = far_en ? far_ack : a_ack_man;

    always #5 clk = ~clk;

    cdc_hs_tx #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .TMO_BITS    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_req   (out_req),
        .a_ack     (a_ack),
        .busy      (busy),
`ifdef CDC_HS_TX_TIMEOUT_EN
        .ack_tmo   (ack_tmo),
`endif
        .proto_err (proto_err)
    );

    // Far-side model: echo each new request phase TURN cycles after seeing it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (far_en && out_req !== far_seen) begin
                far_seen = out_req;
                repeat (TURN) @(posedge clk);
                #1;
                far_ack = far_seen;
            end
        end
    end

    // Count request toggles seen on out_req.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_req !== last_req) n_tog++;
            last_req = out_req;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; a_ack_man = 1'b0; far_en = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req", 32'(out_req), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);

        // INIT lasts S+1 cycles
        rst = 1'b0;
        repeat (S) tick();
        chk("init_ready_lo", 32'(in_ready), 32'd0);
        chk("init_busy_hi", 32'(busy), 32'd1);
        tick();
        chk("init_ready_hi", 32'(in_ready), 32'd1);
        chk("init_busy_lo", 32'(busy), 32'd0);
        chk("init_req", 32'(out_req), 32'd0);
        chk("init_perr", 32'(proto_err), 32'd0);

        // Single word with 5-cycle far turnaround
        far_en = 1'b1;
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0; in_data = '0;
        chk("one_data", out_data, 32'hDEADBEEF);
        chk("one_req", 32'(out_req), 32'd1);
        chk("one_ready", 32'(in_ready), 32'd0);
        chk("one_busy", 32'(busy), 32'd1);
        cnt = 0; held_ok = 1'b1;
        while (!in_ready && cnt < 50) begin
            tick(); cnt++;
            if (out_data !== 32'hDEADBEEF) held_ok = 1'b0;
        end
        chk("one_latency", 32'(cnt), 32'(TURN + S + 1));
        chk("one_hold", 32'(held_ok), 32'd1);

        // Back-to-back words 1,2,3 with in_valid held high
        @(negedge clk);
        n_tog = 0;
        tick();
        in_valid = 1'b1;
        held_ok = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data = 32'(k);
            cnt = 0;
            while (!in_ready && cnt < 50) begin
                tick(); cnt++;
                if (k > 1 && out_data !== 32'(k - 1)) held_ok = 1'b0;
            end
            tick();
            chk("b2b_data", out_data, 32'(k));
        end
        in_valid = 1'b0;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            tick(); cnt++;
            if (out_data !== 32'd3) held_ok = 1'b0;
        end
        chk("b2b_back_idle", 32'(in_ready), 32'd1);
        chk("b2b_hold", 32'(held_ok), 32'd1);
        @(negedge clk);
        chk("b2b_toggles", 32'(n_tog), 32'd3);
        chk("b2b_req", 32'(out_req), 32'd0);

        // Extra ack toggle while IDLE
        tick();
        far_en = 1'b0;
        a_ack_man = 1'b1;
        repeat (S + 1) tick();
        chk("perr_set", 32'(proto_err), 32'd1);
        repeat (5) tick();
        chk("perr_sticky", 32'(proto_err), 32'd1);
        chk("perr_idle", 32'(in_ready), 32'd1);

        // Reset with far side at ack=1 realigns the request phase
        rst = 1'b1;
        tick();
        chk("perr_rst", 32'(proto_err), 32'd0);
        tick();
        rst = 1'b0;
        repeat (S + 1) tick();
        chk("align_req", 32'(out_req), 32'd1);
        chk("align_ready", 32'(in_ready), 32'd1);
        chk("align_perr", 32'(proto_err), 32'd0);

        // Word in WAIT, a second valid is held off, then reset mid-transfer
        in_valid = 1'b1; in_data = 32'h12345678;
        tick();
        in_data = 32'hCAFEF00D;
        repeat (4) tick();
        chk("hold_off_data", out_data, 32'h12345678);
        chk("hold_off_ready", 32'(in_ready), 32'd0);
        chk("hold_off_req", 32'(out_req), 32'd0);
        in_valid = 1'b0;
`ifndef CDC_HS_TX_TIMEOUT_EN
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (S + 1) tick();
        chk("midrst_req", 32'(out_req), 32'd1);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_perr", 32'(proto_err), 32'd0);
        repeat (4) tick();
        chk("midrst_req_stable", 32'(out_req), 32'd1);
`else
        // Never ack: timeout after 15 WAIT cycles (TMO_BITS=4), then a late ack
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (S + 1) tick();
        chk("midrst_req", 32'(out_req), 32'd1);
        chk("tmo_rst", 32'(ack_tmo), 32'd0);
        in_valid = 1'b1; in_data = 32'h000000A5;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        chk("tmo_early", 32'(ack_tmo), 32'd0);
        tick();
        chk("tmo_set", 32'(ack_tmo), 32'd1);
        a_ack_man = 1'b0;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            tick(); cnt++;
        end
        chk("tmo_late_ack", 32'(in_ready), 32'd1);
        chk("tmo_sticky", 32'(ack_tmo), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-domain transmitter of a 2-phase (toggle) request/acknowledge clock-domain crossing.
- Accepts a word on a valid/ready interface and holds it stable on `out_data`.
- Toggles `out_req` to announce the word to the far domain.
- Waits for the far side's `a_ack` toggle, brought into `clk` through the team's synchronizer, before accepting the next word.
- Sits at the sending end of any multi-bit control/status crossing; the far-domain receiver samples `out_data` after its own synchronized `out_req` edge.

Parameters:
- `WIDTH`, default 32: crossed data width in bits (1 to 256).
- `SYNC_STAGES`, default 2: flop stages on the `a_ack` synchronizer (2 to 4).
- `TMO_BITS`, default 16: width of the ack timeout counter; used only with the optional feature.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  source word valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  WIDTH  source word.
- `out_data`  out  WIDTH  registered word toward the far domain; stable while a transfer is outstanding.
- `out_req`  out  1  request toggle, registered, glitch-free.
- `a_ack`  in  1  asynchronous ack toggle from the far domain.
- `busy`  out  1  a transfer is outstanding or the block is initialising.
- `proto_err`  out  1  sticky: ack toggled with no request outstanding.

Behaviour:
- Reset values: `out_data`=0, `out_req`=0, `in_ready`=0, `busy`=1, `proto_err`=0, state=INIT, synchronizer chain=0.
- `a_ack` passes through an internal synchronizer instance (`INIT`=0, synchronous reset from `rst`). The result is `ack_s`.
- States:
  - INIT: a counter runs SYNC_STAGES+1 cycles so `ack_s` reflects the true far-side level. On the final cycle, `out_req` <= `ack_s`, so the phases are aligned, and the state moves to IDLE. This lets the block recover after a local reset when the far side was not reset.
  - IDLE: `in_ready`=1, `busy`=0. On `in_valid`: `out_data` <= `in_data`, `out_req` <= ~`out_req`, go to WAIT.
  - WAIT: `in_ready`=0, `busy`=1. When `ack_s` == `out_req`, go to IDLE.
- Handshake: a transfer occurs when `in_valid` & `in_ready`. `in_ready` is a registered state decode and never depends combinationally on `in_valid`.
- Latency:
  - `out_data` and `out_req` change on the first edge after acceptance.
  - `in_ready` drops on that same edge.
  - `in_ready` rises on the edge after the edge on which `ack_s` first matches.
- Throughput: minimum cycles between acceptances = 1 + far-side turnaround + SYNC_STAGES + 1.
- `out_data` is only written in IDLE on acceptance. It is never modified in WAIT or INIT.
- Protocol error: in IDLE, `ack_s` != `out_req` sets `proto_err` and keeps it set until `rst`. The FSM stays in IDLE.
- Simultaneous events:
  - An `in_valid` presented during WAIT is held off; it is not lost if the source obeys valid/ready.
  - If `ack_s` matches in the same cycle as `rst`, reset wins.
- Reset mid-transfer: the outstanding word is abandoned. INIT realigns `out_req` to the far-side phase, and no spurious request toggle is issued.

Optional Feature:
- Macro `CDC_HS_TX_TIMEOUT_EN`. When defined:
  - Adds output port `ack_tmo` (out, 1, sticky).
  - A TMO_BITS-wide counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches all-ones, `ack_tmo` sets and the counter saturates.
  - The FSM keeps waiting; toggle phase must not be broken.
  - `ack_tmo` clears only on `rst`.
- When not defined: no port, no counter. Behaviour is otherwise identical.

Decomposition:
- Shared package `cdc_hs_pkg` holds:
  - the state encoding constants `CDC_HS_INIT`, `CDC_HS_IDLE`, `CDC_HS_WAIT` (2-bit);
  - the default `SYNC_STAGES` constant.
  - The companion receiver uses the same package.
- One sub-module: the existing `synchronizer` on `a_ack` (`SYNC_STAGES` passed through, `ASYNC_RESET`=0).

Test Plan:
- Reset then idle, `a_ack`=0 → `in_ready`=1 at cycle SYNC_STAGES+2 after `rst` falls; `out_req`=0; `proto_err`=0.
- Send `in_data`=32'hDEADBEEF; model far side with a 5-cycle ack turnaround → `out_data`=DEADBEEF and `out_req`=1 one cycle later; `in_ready` rises 5+SYNC_STAGES+1 cycles after the toggle; `out_data` is unchanged throughout.
- Back-to-back words 1, 2, 3 with `in_valid` held high → exactly three `out_req` toggles; each `out_data` value held until its ack; no word skipped.
- Pulse an extra `a_ack` toggle while IDLE → `proto_err`=1 within SYNC_STAGES+1 cycles and stays 1 until `rst`.
- Assert `rst` in WAIT with `a_ack`=1 held (far side not reset) → after INIT, `out_req`=1, `in_ready`=1, no toggle issued.
- With `CDC_HS_TX_TIMEOUT_EN` defined and `TMO_BITS`=4, never ack → `ack_tmo`=1 after 15 WAIT cycles; a later ack returns the FSM to IDLE and `ack_tmo` stays 1.
